// File: rtl/peripheral_spram_bist_pkg.sv
// rtl/peripheral_spram_bist_pkg.sv - shared types and constants for the SPRAM BIST master
// Purpose: FSM state type, Wishbone burst codes, LFSR polynomial and pattern codes.
package peripheral_spram_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WGAP,
        READ,
        RGAP,
        DONE
    } bist_state_t;

    localparam logic [2:0]  CTI_INCR   = 3'b010;
    localparam logic [2:0]  CTI_EOB    = 3'b111;
    localparam logic [1:0]  BTE_LINEAR = 2'b00;

    localparam logic [31:0] LFSR_POLY  = 32'h8020_0003;

    localparam logic [1:0]  PAT_ADDR   = 2'd0;
    localparam logic [1:0]  PAT_LFSR   = 2'd1;
    localparam logic [1:0]  PAT_CONST  = 2'd2;
    localparam logic [1:0]  PAT_NADDR  = 2'd3;

    // Right-shifting Galois step: feedback bit is the LSB shifted out.
    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/peripheral_spram_bist_patgen.sv
// rtl/peripheral_spram_bist_patgen.sv - BIST data pattern generator
// Purpose: produces the write word in the write phase and the expected word in the read phase.
// Ports: clk_i/rst_ni clock and async active-low reset; pattern_i selects the pattern;
//        adr_i current byte address; const_i constant word; load_i reloads the LFSR seed
//        (wins over step_i); step_i advances the LFSR once; data_o pattern word.
module peripheral_spram_bist_patgen
    import peripheral_spram_bist_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_0001
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [1:0]  pattern_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] const_i,
    input  logic        load_i,
    input  logic        step_i,
    output logic [31:0] data_o
);

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = SEED;
        end else if (step_i) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    always_comb begin
        data_o = adr_i;
        unique case (pattern_i)
            PAT_ADDR:  data_o = adr_i;
            PAT_LFSR:  data_o = lfsr_q;
            PAT_CONST: data_o = const_i;
            PAT_NADDR: data_o = ~adr_i;
            default:   data_o = adr_i;
        endcase
    end

endmodule

// File: rtl/peripheral_spram_wb_bist.sv
// rtl/peripheral_spram_wb_bist.sv - Wishbone burst BIST master for the SPRAM
// Purpose: writes a pattern over the whole RAM in linear bursts, reads it back and compares.
// Ports: wb_clk_i/wb_rst_ni clock and async active-low reset; start_i/pattern_i/const_i test
//        request; busy_o/done_o/err_o/bus_err_o/err_adr_o/err_cnt_o status; wb_* Wishbone master.
module peripheral_spram_wb_bist
    import peripheral_spram_bist_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned BURST_LEN = 16,
    parameter logic [31:0] SEED      = 32'hACE1_0001
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        start_i,
    input  logic [1:0]  pattern_i,
    input  logic [31:0] const_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        bus_err_o,
    output logic [31:0] err_adr_o,
    output logic [15:0] err_cnt_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [2:0]  wb_cti_o,
    output logic [1:0]  wb_bte_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    localparam int unsigned    BW        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0]  LAST_BEAT = BW'(BURST_LEN - 1);
    localparam logic [31:0]    LAST_ADR  = 32'(DEPTH - 4);

    bist_state_t   state_q,   state_d;
    logic [31:0]   adr_q,     adr_d;
    logic [BW-1:0] beat_q,    beat_d;
    logic [1:0]    pattern_q, pattern_d;
    logic [31:0]   const_q,   const_d;
    logic          cyc_q,     cyc_d;
    logic          stb_q,     stb_d;
    logic          we_q,      we_d;
    logic          busy_q,    busy_d;
    logic          done_q,    done_d;
    logic          err_q,     err_d;
    logic          bus_err_q, bus_err_d;
    logic [31:0]   err_adr_q, err_adr_d;
    logic [15:0]   err_cnt_q, err_cnt_d;

    logic          pat_load;
    logic          pat_step;
    logic [31:0]   pat_data;

    peripheral_spram_bist_patgen #(
        .SEED(SEED)
    ) u_patgen (
        .clk_i    (wb_clk_i),
        .rst_ni   (wb_rst_ni),
        .pattern_i(pattern_q),
        .adr_i    (adr_q),
        .const_i  (const_q),
        .load_i   (pat_load),
        .step_i   (pat_step),
        .data_o   (pat_data)
    );

    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        beat_d    = beat_q;
        pattern_d = pattern_q;
        const_d   = const_q;
        cyc_d     = cyc_q;
        stb_d     = stb_q;
        we_d      = we_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        bus_err_d = bus_err_q;
        err_adr_d = err_adr_q;
        err_cnt_d = err_cnt_q;
        pat_load  = 1'b0;
        pat_step  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    pattern_d = pattern_i;
                    const_d   = const_i;
                    err_d     = 1'b0;
                    bus_err_d = 1'b0;
                    err_adr_d = 32'h0;
                    err_cnt_d = 16'h0;
                    done_d    = 1'b0;
                    busy_d    = 1'b1;
                    adr_d     = 32'h0;
                    beat_d    = '0;
                    pat_load  = 1'b1;
                    cyc_d     = 1'b1;
                    stb_d     = 1'b1;
                    we_d      = 1'b1;
                    state_d   = WRITE;
                end
            end
            WRITE, READ: begin
                if (wb_err_i) begin
                    cyc_d     = 1'b0;
                    stb_d     = 1'b0;
                    we_d      = 1'b0;
                    err_d     = 1'b1;
                    bus_err_d = 1'b1;
                    err_adr_d = adr_q;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end else if (wb_ack_i) begin
                    if (state_q == READ && wb_dat_i != pat_data) begin
                        err_d = 1'b1;
                        if (!err_q) begin
                            err_adr_d = adr_q;
                        end
                        if (err_cnt_q != 16'hFFFF) begin
                            err_cnt_d = err_cnt_q + 16'd1;
                        end
                    end
                    adr_d    = adr_q + 32'd4;
                    beat_d   = beat_q + BW'(1);
                    pat_step = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                        state_d = (state_q == WRITE) ? WGAP : RGAP;
                    end
                    if (adr_q == LAST_ADR) begin
                        beat_d = '0;
                        cyc_d  = 1'b0;
                        stb_d  = 1'b0;
                        we_d   = 1'b0;
                        if (state_q == WRITE) begin
                            // Read phase regenerates the same sequence from the seed.
                            adr_d    = 32'h0;
                            pat_load = 1'b1;
                            state_d  = RGAP;
                        end else begin
                            // Hold the final address rather than stepping past the RAM.
                            adr_d   = adr_q;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = DONE;
                        end
                    end
                end
            end
            WGAP: begin
                cyc_d   = 1'b1;
                stb_d   = 1'b1;
                state_d = WRITE;
            end
            RGAP: begin
                cyc_d   = 1'b1;
                stb_d   = 1'b1;
                state_d = READ;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= IDLE;
            adr_q     <= 32'h0;
            beat_q    <= '0;
            pattern_q <= 2'd0;
            const_q   <= 32'h0;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            bus_err_q <= 1'b0;
            err_adr_q <= 32'h0;
            err_cnt_q <= 16'h0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            beat_q    <= beat_d;
            pattern_q <= pattern_d;
            const_q   <= const_d;
            cyc_q     <= cyc_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            bus_err_q <= bus_err_d;
            err_adr_q <= err_adr_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign bus_err_o = bus_err_q;
    assign err_adr_o = err_adr_q;
    assign err_cnt_o = err_cnt_q;
    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = (stb_q && we_q) ? pat_data : 32'h0;
    assign wb_sel_o  = stb_q ? 4'hF : 4'h0;
    assign wb_we_o   = we_q;
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = stb_q;
    assign wb_cti_o  = !stb_q ? 3'b000 : ((beat_q == LAST_BEAT) ? CTI_EOB : CTI_INCR);
    assign wb_bte_o  = BTE_LINEAR;

endmodule

// File: tb/tb_peripheral_spram_wb_bist.sv
// tb/tb_peripheral_spram_wb_bist.sv - scoreboard bench for the SPRAM BIST master with a RAM slave model
module tb_peripheral_spram_wb_bist;

    localparam int          DEPTH = 1024;
    localparam int          BL    = 16;
    localparam int          WORDS = DEPTH / 4;
    localparam logic [31:0] SEED  = 32'hACE1_0001;
    localparam logic [31:0] POLY  = 32'h8020_0003;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  pattern = 2'd0;
    logic [31:0] cnst = 32'h0;
    logic        busy, done, err, bus_err;
    logic [31:0] err_adr;
    logic [15:0] err_cnt;
    logic [31:0] wb_adr, wb_dat_o;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_cyc, wb_stb;
    logic [2:0]  wb_cti;
    logic [1:0]  wb_bte;
    logic [31:0] wb_dat_i = 32'h0;
    logic        wb_ack = 1'b0;
    logic        wb_err = 1'b0;

    always #5 clk = ~clk;

    peripheral_spram_wb_bist #(
        .DEPTH(DEPTH), .BURST_LEN(BL), .SEED(SEED)
    ) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start), .pattern_i(pattern),
        .const_i(cnst), .busy_o(busy), .done_o(done), .err_o(err), .bus_err_o(bus_err),
        .err_adr_o(err_adr), .err_cnt_o(err_cnt), .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o),
        .wb_sel_o(wb_sel), .wb_we_o(wb_we), .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb),
        .wb_cti_o(wb_cti), .wb_bte_o(wb_bte), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack),
        .wb_err_i(wb_err)
    );

    typedef struct packed {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
        logic [2:0]  cti;
    } beat_t;

    typedef struct packed {
        logic        err;
        logic        bus_err;
        logic [31:0] err_adr;
        logic [15:0] err_cnt;
    } res_t;

    beat_t       beat_q[$];
    res_t        res_q[$];
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    logic [31:0] lfsr_seq[WORDS];
    logic [31:0] mem[WORDS];
    bit          corrupt[WORDS];
    bit          stall_en = 1'b0;
    bit          err_inj = 1'b0;
    logic [31:0] err_inj_adr = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pat_word(input int p, input logic [31:0] c, input int w);
        logic [31:0] a;
        a = 32'(w * 4);
        case (p)
            0:       return a;
            1:       return lfsr_seq[w];
            2:       return c;
            default: return ~a;
        endcase
    endfunction

    // Expected bus traffic and final status for one test; err_word < 0 means no bus error.
    task automatic plan(input int p, input logic [31:0] c, input int err_word);
        res_t r;
        r = '0;
        for (int ph = 0; ph < 2; ph++) begin
            for (int w = 0; w < WORDS; w++) begin
                beat_t b;
                if (err_word >= 0 && (ph == 1 || w > err_word)) break;
                b.adr = 32'(w * 4);
                b.we  = (ph == 0);
                b.dat = pat_word(p, c, w);
                b.cti = ((w % BL) == BL - 1) ? 3'b111 : 3'b010;
                beat_q.push_back(b);
            end
        end
        if (err_word >= 0) begin
            r.err = 1'b1; r.bus_err = 1'b1; r.err_adr = 32'(err_word * 4);
        end else begin
            for (int w = 0; w < WORDS; w++) begin
                if (corrupt[w]) begin
                    if (!r.err) r.err_adr = 32'(w * 4);
                    r.err = 1'b1;
                    r.err_cnt = r.err_cnt + 16'd1;
                end
            end
        end
        res_q.push_back(r);
    endtask

    // RAM slave + beat monitor: decides each response half a cycle before the sampling edge.
    bit    need_draw = 1'b1;
    int    wait_c = 0;
    beat_t cur;
    always @(negedge clk) begin
        wb_ack = 1'b0;
        wb_err = 1'b0;
        if (rst_n && wb_cyc && wb_stb) begin
            if (need_draw) begin
                wait_c = stall_en ? int'($urandom_range(0, 3)) : 0;
                need_draw = 1'b0;
            end
            if (wait_c > 0) begin
                wait_c--;
            end else begin
                if (beat_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_beat: got beat at adr %h expected none", wb_adr);
                end else begin
                    cur = beat_q.pop_front();
                    check("beat_adr", wb_adr, cur.adr);
                    check("beat_we", 32'(wb_we), 32'(cur.we));
                    if (cur.we) check("beat_wdata", wb_dat_o, cur.dat);
                    check("beat_cti", 32'(wb_cti), 32'(cur.cti));
                    check("beat_sel", 32'(wb_sel), 32'hF);
                    check("beat_bte", 32'(wb_bte), 32'h0);
                end
                if (err_inj && wb_we && wb_adr == err_inj_adr) begin
                    wb_err = 1'b1;
                end else begin
                    wb_ack = 1'b1;
                    if (wb_we) mem[wb_adr[9:2]] = wb_dat_o;
                    else wb_dat_i = mem[wb_adr[9:2]] ^ {31'b0, corrupt[wb_adr[9:2]]};
                end
                need_draw = 1'b1;
            end
        end else begin
            need_draw = 1'b1;
        end
    end

    // Result monitor: pops the expected status when done_o rises; also checks gap length.
    logic done_prev = 1'b0;
    int   gap_len = 0;
    res_t er;
    always @(negedge clk) begin
        if (!rst_n) begin
            gap_len = 0;
        end else begin
            if (busy && !wb_cyc) begin
                gap_len++;
            end else begin
                if (wb_cyc && gap_len != 0) check("gap_len", 32'(gap_len), 32'd1);
                gap_len = 0;
            end
            if (done && !done_prev) begin
                done_cnt++;
                if (res_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got done_o=1 expected no test");
                end else begin
                    er = res_q.pop_front();
                    check("res_err", 32'(err), 32'(er.err));
                    check("res_bus_err", 32'(bus_err), 32'(er.bus_err));
                    check("res_err_adr", err_adr, er.err_adr);
                    check("res_err_cnt", 32'(err_cnt), 32'(er.err_cnt));
                    check("res_busy", 32'(busy), 32'd0);
                    check("res_cyc", 32'(wb_cyc), 32'd0);
                end
            end
        end
        done_prev = done;
    end

    task automatic launch(input int p, input logic [31:0] c);
        @(negedge clk);
        pattern = 2'(p);
        cnst = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Inputs change after acceptance; the latched values must be used.
        pattern = 2'(p) ^ 2'd1;
        cnst = ~c;
        check("start_cyc", 32'(wb_cyc), 32'd1);
        check("start_busy", 32'(busy), 32'd1);
        check("start_done_clr", 32'(done), 32'd0);
    endtask

    task automatic run(input int p, input logic [31:0] c, input int err_word,
                       input bit stall, input bit mid_start);
        int d0;
        stall_en = stall;
        err_inj = (err_word >= 0);
        err_inj_adr = 32'(err_word * 4);
        plan(p, c, err_word);
        d0 = done_cnt;
        launch(p, c);
        for (int k = 0; k < 20000 && done_cnt == d0; k++) begin
            @(negedge clk);
            if (mid_start) start = (k == 300);
        end
        start = 1'b0;
        if (done_cnt == d0) begin
            checks++; errors++;
            $display("FAIL done_timeout: got done_o=0 expected 1");
        end
        check("leftover_beats", 32'(beat_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        check("done_held", 32'(done), 32'd1);
        check("idle_cyc", 32'(wb_cyc), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        err_inj = 1'b0;
    endtask

    initial begin
        logic [31:0] l;
        l = SEED;
        for (int w = 0; w < WORDS; w++) begin
            lfsr_seq[w] = l;
            if (l[0]) l = (l >> 1) ^ POLY;
            else l = l >> 1;
            mem[w] = 32'h0;
            corrupt[w] = 1'b0;
        end

        repeat (3) @(negedge clk);
        check("rst_cyc", 32'(wb_cyc), 32'd0);
        check("rst_stb", 32'(wb_stb), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_adr", wb_adr, 32'd0);
        check("rst_sel", 32'(wb_sel), 32'd0);
        check("rst_cti", 32'(wb_cti), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst_n = 1'b1;

        // 1: address pattern
        run(0, 32'h0, -1, 1'b0, 1'b0);
        check("mem_0x010", mem[4], 32'h0000_0010);

        // 2: LFSR pattern
        run(1, 32'h0, -1, 1'b0, 1'b0);

        // 3: constant with two corrupted read words
        corrupt[32'h1F8 >> 2] = 1'b1;
        corrupt[32'h3FC >> 2] = 1'b1;
        run(2, 32'hDEAD_BEEF, -1, 1'b0, 1'b0);
        corrupt[32'h1F8 >> 2] = 1'b0;
        corrupt[32'h3FC >> 2] = 1'b0;

        // 4: bus error on write beat at 0x040
        run(0, 32'h0, 16, 1'b0, 1'b0);

        // 5: reset while the read beat at 0x200 is on the bus
        plan(0, 32'h0, -1);
        launch(0, 32'h0);
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (wb_stb && !wb_we && wb_adr == 32'h200) break;
        end
        check("reset_point_adr", wb_adr, 32'h200);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_cyc", 32'(wb_cyc), 32'd0);
        check("async_rst_stb", 32'(wb_stb), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        beat_q.delete();
        res_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run(3, 32'h0, -1, 1'b0, 1'b0);

        // 6: random stalls, random pattern, start pulsed while busy
        for (int t = 0; t < 3; t++) begin
            run(int'($urandom_range(0, 3)), $urandom, -1, 1'b1, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
